// File: rtl/muldiv_iter.sv
// -----------------------------------------------------------------------------
// muldiv_iter -- shared iterative multiply/divide engine for the execute stage.
//
// Signed and unsigned multiply (shift-add, MUL_BITS multiplier bits per cycle)
// and divide (restoring, one quotient bit per cycle) on WIDTH-bit operands.
// The operation runs on unsigned magnitudes, and the sign is fixed up when
// the result register is loaded.
//
// Ports:
//   clk     rising-edge clock
//   rst     synchronous active-high reset
//   start   request level, held by requester until ready is seen
//   op      00 MULT, 01 MULTU, 10 DIV, 11 DIVU (sampled with start)
//   a, b    multiplicand/dividend, multiplier/divisor (sampled with start)
//   flush   abort the current operation
//   busy    high while in MUL, DIV or DONE
//   ready   one-cycle pulse, result valid
//   result  MUL: {hi,lo} product; DIV: {remainder, quotient}
//
// Optional build macro: MULDIV_EARLY_OUT_EN. When it is defined, a multiply
// by zero and a divide with |a| < |b| finish straight from IDLE.
// -----------------------------------------------------------------------------
module muldiv_iter #(
    parameter int WIDTH    = 32,
    parameter int MUL_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 flush,
    output logic                 busy,
    output logic                 ready,
    output logic [2*WIDTH-1:0]   result
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] MUL_LAST = CW'(WIDTH / MUL_BITS - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic               neg_q;      // negate product / quotient
    logic               neg_r;      // negate remainder
    logic [WIDTH-1:0]   opnd;       // MUL: |multiplicand|, DIV: |divisor|
    logic [2*WIDTH-1:0] acc;        // MUL: {hi, multiplier}, DIV: low half holds dividend/quotient
    logic [WIDTH-1:0]   rem;        // partial remainder between iterations

    // Operand decode in IDLE
    logic             is_div, signed_op, a_neg, b_neg, early;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign is_div    = op[1];
    assign signed_op = ~op[0];
    assign a_neg     = signed_op & a[WIDTH-1];
    assign b_neg     = signed_op & b[WIDTH-1];
    assign a_mag     = a_neg ? -a : a;
    assign b_mag     = b_neg ? -b : b;

`ifdef MULDIV_EARLY_OUT_EN
    assign early = is_div ? ((b != '0) && (a_mag < b_mag))
                          : ((a_mag == '0) || (b_mag == '0));
`else
    assign early = 1'b0;
`endif

    // Multiply step: add opnd * (low MUL_BITS of the multiplier) into hi,
    // then shift the whole accumulator right by MUL_BITS.
    logic [WIDTH+MUL_BITS-1:0] mul_pp, mul_sum;
    logic [2*WIDTH-1:0]        mul_next, mul_fix;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        mul_pp = '0;
        for (int j = 0; j < MUL_BITS; j++) begin
            if (acc[j]) begin
                mul_pp = mul_pp + ((WIDTH+MUL_BITS)'(opnd) << j);
            end
        end
        mul_sum  = {{MUL_BITS{1'b0}}, acc[2*WIDTH-1:WIDTH]} + mul_pp;
        mul_next = {mul_sum, acc[WIDTH-1:MUL_BITS]};
        mul_fix  = neg_q ? -mul_next : mul_next;
    end

    // Restoring divide step. div_shift is the WIDTH+1-bit partial remainder.
    // The sign of the trial subtraction decides the quotient bit.
    logic [WIDTH:0]   div_shift, div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] rem_next, quo_next, rem_fix, quo_fix;

    always_comb begin
        div_shift = {rem, acc[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
        div_ge    = ~div_diff[WIDTH];
        rem_next  = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
        quo_next  = {acc[WIDTH-2:0], div_ge};
        quo_fix   = neg_q ? -quo_next : quo_next;
        rem_fix   = neg_r ? -rem_next : rem_next;
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments only, so every
        // register in this block sees the value from before the edge.
        if (rst) begin
            // NOTE: every register is cleared here because the reset values are
            // visible on the outputs or are consumed on the first iteration.
            state  <= S_IDLE;
            cnt    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            opnd   <= '0;
            acc    <= '0;
            rem    <= '0;
            result <= '0;
        end else if (flush) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        neg_q <= a_neg ^ b_neg;
                        neg_r <= a_neg;
                        cnt   <= '0;
                        if (is_div && (b == '0)) begin
                            result <= {a, {WIDTH{1'b1}}};
                            state  <= S_DONE;
                        end else if (early) begin
                            // Remainder is the raw dividend, so it already has the right sign.
                            result <= is_div ? {a, {WIDTH{1'b0}}} : '0;
                            state  <= S_DONE;
                        end else if (is_div) begin
                            opnd  <= b_mag;
                            acc   <= {{WIDTH{1'b0}}, a_mag};
                            rem   <= '0;
                            state <= S_DIV;
                        end else begin
                            opnd  <= a_mag;
                            acc   <= {{WIDTH{1'b0}}, b_mag};
                            state <= S_MUL;
                        end
                    end
                end
                S_MUL: begin
                    acc <= mul_next;
                    if (cnt == MUL_LAST) begin
                        result <= mul_fix;
                        cnt    <= '0;
                        state  <= S_DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_DIV: begin
                    acc <= {acc[2*WIDTH-1:WIDTH], quo_next};
                    rem <= rem_next;
                    if (cnt == DIV_LAST) begin
                        result <= {rem_fix, quo_fix};
                        cnt    <= '0;
                        state  <= S_DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= S_IDLE;   // S_DONE
            endcase
        end
    end

    assign busy  = (state != S_IDLE);
    assign ready = (state == S_DONE);

endmodule

// File: tb/tb_muldiv_iter.sv
// -----------------------------------------------------------------------------
// tb_muldiv_iter -- scoreboard bench for muldiv_iter.
// Instance 0 uses MUL_BITS=1 and instance 1 uses MUL_BITS=4. The drivers push
// the expected {result, latency} when a request is accepted. A monitor per
// instance pops an entry and compares it whenever ready is high.
// -----------------------------------------------------------------------------
module tb_muldiv_iter;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

`ifdef MULDIV_EARLY_OUT_EN
    localparam int LAT_EO = 1;
`else
    localparam int LAT_EO = 33;
`endif

    typedef struct {
        logic [63:0] res;
        int          lat;
        int          acc_cyc;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_s [2];
    logic [1:0]  op_s    [2];
    logic [31:0] a_s     [2];
    logic [31:0] b_s     [2];
    logic        flush_s [2];
    logic        busy_s  [2];
    logic        ready_s [2];
    logic [63:0] result_s[2];

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb0[$];
    exp_t sb1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    muldiv_iter #(.WIDTH(32), .MUL_BITS(1)) dut0 (
        .clk(clk), .rst(rst), .start(start_s[0]), .op(op_s[0]), .a(a_s[0]), .b(b_s[0]),
        .flush(flush_s[0]), .busy(busy_s[0]), .ready(ready_s[0]), .result(result_s[0])
    );

    muldiv_iter #(.WIDTH(32), .MUL_BITS(4)) dut1 (
        .clk(clk), .rst(rst), .start(start_s[1]), .op(op_s[1]), .a(a_s[1]), .b(b_s[1]),
        .flush(flush_s[1]), .busy(busy_s[1]), .ready(ready_s[1]), .result(result_s[1])
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    task automatic monitor(input int idx);
        exp_t e;
        forever begin
            @(negedge clk);
            if (ready_s[idx]) begin
                if ((idx == 0 && sb0.size() == 0) || (idx == 1 && sb1.size() == 0)) begin
                    check($sformatf("dut%0d unexpected_ready", idx), 64'(ready_s[idx]), 64'd0);
                end else begin
                    e = (idx == 0) ? sb0.pop_front() : sb1.pop_front();
                    check({e.name, " result"}, result_s[idx], e.res);
                    check({e.name, " latency"}, 64'(cyc - e.acc_cyc + 1), 64'(e.lat));
                end
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    task automatic wait_idle(input int idx);
        for (int i = 0; i < 200; i++) begin
            if (!busy_s[idx]) return;
            @(negedge clk);
        end
        check($sformatf("dut%0d idle_timeout", idx), 64'(busy_s[idx]), 64'd0);
    endtask

    // Full request: the expectation is queued at the accept edge, and start
    // is held until ready is seen.
    task automatic run_op(input int idx, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] res, input int lat,
                          input string name);
        exp_t e;
        bit   got;
        wait_idle(idx);
        op_s[idx] = op; a_s[idx] = a; b_s[idx] = b; start_s[idx] = 1'b1;
        @(posedge clk); #1;
        e.res = res; e.lat = lat; e.acc_cyc = cyc; e.name = name;
        if (idx == 0) sb0.push_back(e); else sb1.push_back(e);
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            got = ready_s[idx];
        end
        if (!got) check({name, " ready_timeout"}, 64'(ready_s[idx]), 64'd1);
        start_s[idx] = 1'b0;
    endtask

    // A request that the bench aborts later, so no expectation is queued.
    task automatic start_only(input int idx, input logic [1:0] op, input logic [31:0] a,
                              input logic [31:0] b);
        wait_idle(idx);
        op_s[idx] = op; a_s[idx] = a; b_s[idx] = b; start_s[idx] = 1'b1;
        @(posedge clk); #1;
        start_s[idx] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            start_s[i] = 1'b0; op_s[i] = 2'b00; a_s[i] = '0; b_s[i] = '0; flush_s[i] = 1'b0;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("dut%0d reset busy", i), 64'(busy_s[i]), 64'd0);
            check($sformatf("dut%0d reset ready", i), 64'(ready_s[i]), 64'd0);
            check($sformatf("dut%0d reset result", i), result_s[i], 64'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors, MUL_BITS=1
        run_op(0, OP_MULT,  32'hFFFFFFFD, 32'd5,        64'hFFFFFFFF_FFFFFFF1, 33, "mult -3*5");
        run_op(0, OP_MULTU, 32'hFFFFFFFF, 32'd2,        64'h00000001_FFFFFFFE, 33, "multu ffffffff*2");
        run_op(0, OP_MULT,  32'd7,        32'hFFFFFFFA, 64'hFFFFFFFF_FFFFFFD6, 33, "mult 7*-6");
        run_op(0, OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001, 33, "mult -1*-1");
        run_op(0, OP_MULT,  32'h80000000, 32'h80000000, 64'h40000000_00000000, 33, "mult min*min");
        run_op(0, OP_MULTU, 32'd0,        32'd5,        64'h00000000_00000000, LAT_EO, "multu 0*5");
        run_op(0, OP_DIV,   32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD, 33, "div -7/2");
        run_op(0, OP_DIV,   32'd7,        32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33, "div 7/-2");
        run_op(0, OP_DIVU,  32'd100,      32'd7,        64'h00000002_0000000E, 33, "divu 100/7");
        run_op(0, OP_DIV,   32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33, "div min/-1");
        run_op(0, OP_DIVU,  32'd10,       32'd0,        64'h0000000A_FFFFFFFF, 1,  "divu 10/0");
        run_op(0, OP_DIV,   32'hFFFFFFFB, 32'd0,        64'hFFFFFFFB_FFFFFFFF, 1,  "div -5/0");
        run_op(0, OP_DIVU,  32'd3,        32'd9,        64'h00000003_00000000, LAT_EO, "divu 3/9");
        run_op(0, OP_DIVU,  32'hFFFFFFFF, 32'd1,        64'h00000000_FFFFFFFF, 33, "divu ffffffff/1");

        // Flush at iteration 10 of a DIVU: back to IDLE, no ready, result kept
        start_only(0, OP_DIVU, 32'd1000, 32'd3);
        repeat (10) @(negedge clk);
        flush_s[0] = 1'b1;
        @(posedge clk); #1;
        flush_s[0] = 1'b0;
        check("flush busy", 64'(busy_s[0]), 64'd0);
        check("flush ready", 64'(ready_s[0]), 64'd0);
        check("flush result_kept", result_s[0], 64'h00000000_FFFFFFFF);
        repeat (3) @(negedge clk);
        check("flush stays_idle", 64'(busy_s[0]), 64'd0);
        run_op(0, OP_MULTU, 32'd6, 32'd7, 64'h00000000_0000002A, 33, "multu 6*7 after flush");

        // flush and start together in IDLE: the request is ignored
        wait_idle(0);
        op_s[0] = OP_MULTU; a_s[0] = 32'd2; b_s[0] = 32'd3;
        start_s[0] = 1'b1; flush_s[0] = 1'b1;
        @(posedge clk); #1;
        start_s[0] = 1'b0; flush_s[0] = 1'b0;
        check("flush+start busy", 64'(busy_s[0]), 64'd0);
        @(posedge clk); #1;
        check("flush+start result", result_s[0], 64'h00000000_0000002A);

        // Reset mid-DIV
        start_only(0, OP_DIVU, 32'd1000, 32'd3);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid busy", 64'(busy_s[0]), 64'd0);
        check("rst_mid ready", 64'(ready_s[0]), 64'd0);
        check("rst_mid result", result_s[0], 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // MUL_BITS=4 instance
        run_op(1, OP_MULTU, 32'hFFFFFFFF, 32'd2, 64'h00000001_FFFFFFFE, 9, "mb4 multu ffffffff*2");
        run_op(1, OP_MULT,  32'hFFFFFFFD, 32'd5, 64'hFFFFFFFF_FFFFFFF1, 9, "mb4 mult -3*5");
        run_op(1, OP_MULTU, 32'h12345678, 32'h9ABCDEF0, 64'h0B00EA4E_242D2080, 9, "mb4 multu big");
        run_op(1, OP_DIVU,  32'd100, 32'd7, 64'h00000002_0000000E, 33, "mb4 divu 100/7");

        repeat (5) @(negedge clk);
        check("dut0 scoreboard_empty", 64'(sb0.size()), 64'd0);
        check("dut1 scoreboard_empty", 64'(sb1.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/muldiv_iter.md
Name: muldiv_iter

Overview:
Parametrised iterative multiply/divide unit serving the execute stage; it replaces the single-cycle multiply and the external divider with one shared multi-cycle engine.
- Handles signed and unsigned MULT and DIV on WIDTH-bit operands.
- Returns a 2*WIDTH-bit {hi,lo} result for the HI/LO register path.
- Uses a start/ready handshake and a flush input for exception or branch annulment.

Parameters:
WIDTH, 32, operand width in bits; must be even, >=8.
MUL_BITS, 1, multiplier bits retired per MUL iteration; must be 1, 2 or 4 and divide WIDTH.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous active-high reset.
start  in  1  request; level, held by requester until ready is seen.
op  in  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU; sampled with start.
a  in  WIDTH  multiplicand / dividend; sampled with start.
b  in  WIDTH  multiplier / divisor; sampled with start.
flush  in  1  abort current operation.
busy  out  1  high in MUL, DIV, DONE states.
ready  out  1  one-cycle pulse; result valid.
result  out  2*WIDTH  MUL: full product {hi,lo}; DIV: {remainder, quotient}.

Behaviour:
- Reset (rst=1 at edge): state IDLE, busy=0, ready=0, result=0, iteration counter=0, operand/accumulator registers=0. Reset wins over all other inputs, including mid-operation.
- States: IDLE, MUL, DIV, DONE.
- IDLE transitions:
  - start=1 and flush=0: latch op, magnitudes |a|,|b| (signed ops) or raw a,b (unsigned ops), and sign-fix flags.
  - Then go to MUL or DIV with counter=0.
  - DIV/DIVU with b=0: go directly to DONE.
- MUL: shift-add, MUL_BITS multiplier bits per cycle; WIDTH/MUL_BITS cycles, then DONE.
- DIV: restoring division, one quotient bit per cycle; WIDTH cycles, then DONE.
- DONE: ready=1 for exactly one cycle; result register loaded with the sign-corrected value on entry; next state IDLE unconditionally.
- Requester must drop start in the cycle ready=1. start seen high in IDLE afterwards is a new request.
- Latency, start-accept edge to ready-high cycle:
  - MUL: WIDTH/MUL_BITS+1 cycles.
  - DIV: WIDTH+1 cycles.
  - Divide by zero: 1 cycle.
- Sign rules, signed ops:
  - Product negated if a[WIDTH-1]^b[WIDTH-1].
  - Quotient negated if signs differ.
  - Remainder takes the dividend's sign.
  - MIN/-1: quotient=MIN, remainder=0, no trap.
- Divide by zero (signed or unsigned): quotient all-ones, remainder=a.
- result holds its value from DONE until the next DONE or reset; never changes in IDLE/MUL/DIV.
- flush=1 in any state: next state IDLE, ready stays 0, result unchanged, counter cleared.
- flush and start together in IDLE: flush wins, request ignored.
- flush in the DONE cycle: ready still pulses (result already committed); requester discards it.
- start changes while busy: ignored; op/a/b are not re-sampled.
- All arithmetic is unsigned internally on WIDTH-bit magnitudes; accumulator is 2*WIDTH bits for MUL and WIDTH+1 bits for the partial remainder.

Optional Feature:
MULDIV_EARLY_OUT_EN
- Defined:
  - In IDLE, MUL/MULTU with a magnitude or b magnitude equal to 0 goes directly to DONE with result 0 (latency 1).
  - DIV/DIVU with |a| < |b| (nonzero b) goes directly to DONE with quotient 0 and remainder=a (latency 1).
- Not defined: these cases take the full iteration count with identical results.
- The flush rules apply either way.

Test Plan:
- WIDTH=32, MUL_BITS=1, MULT a=0xFFFFFFFD (-3), b=5 -> ready 33 cycles after accept, result=0xFFFFFFFF_FFFFFFF1.
- MULTU a=0xFFFFFFFF, b=2; repeat with MUL_BITS=4 -> result=0x00000001_FFFFFFFE, ready after 33 and 9 cycles respectively.
- DIV a=0xFFFFFFF9 (-7), b=2 -> ready after 33 cycles, result={0xFFFFFFFF, 0xFFFFFFFD}; DIVU a=100, b=7 -> {0x00000002, 0x0000000E}.
- DIV a=0x80000000, b=0xFFFFFFFF -> {0x00000000, 0x80000000}; DIVU a=10, b=0 -> ready after 1 cycle, {0x0000000A, 0xFFFFFFFF}.
- DIVU started, flush at iteration 10 -> IDLE next cycle, no ready pulse, result keeps prior value; new MULTU 6*7 then yields 0x00000000_0000002A.
- rst asserted mid-DIV -> busy=0, ready=0, result=0 next cycle; with MULDIV_EARLY_OUT_EN, DIVU 3/9 -> ready after 1 cycle, {0x00000003, 0x00000000}.
